uart_reg_bridge: RTL and testbench

// - Command responder on the far side of the UART byte interface.
// - Consumes received bytes as write/read command frames, drives a register-file port, and returns read data as a byte to the UART transmitter.
// - Single CLK domain: the RX/TX byte strobes reach it already synchronised.

---
 rtl/uart_bridge_pkg.sv | 24 ++
 rtl/uart_bridge_tmr.sv | 31 +++
 rtl/uart_reg_bridge.sv | 159 +++++++++++++++
 tb/tb_uart_reg_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART command bridge: FSM state encoding and default opcodes.
`timescale 1ns/1ps
package uart_bridge_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WR_ADDR    = 3'd1;
  localparam logic [2:0] ST_WR_DATA    = 3'd2;
  localparam logic [2:0] ST_RD_ADDR    = 3'd3;
  localparam logic [2:0] ST_RD_WAIT    = 3'd4;
  localparam logic [2:0] ST_TX_SEND    = 3'd5;
  localparam logic [2:0] ST_TX_WAIT_HI = 3'd6;
  localparam logic [2:0] ST_TX_WAIT_LO = 3'd7;

  localparam logic [7:0] DEF_CMD_WR   = 8'hAA;
  localparam logic [7:0] DEF_CMD_RD   = 8'hBB;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h5A;

  // States in which an incomplete frame can be abandoned by the inter-byte timeout.
  function automatic logic is_timed(input logic [2:0] st);
    return (st == ST_WR_ADDR) || (st == ST_WR_DATA) ||
           (st == ST_RD_ADDR) || (st == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/uart_bridge_tmr.sv
// Frame timeout counter: clears on clr, counts while en, flags expiry at TIMEOUT_CYC-1.
`timescale 1ns/1ps
module uart_bridge_tmr #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Saturating up-counter so a stalled count never wraps back below LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command-frame responder driving a register-file port.
// Optional write acknowledge byte enabled by macro UART_REG_BRIDGE_WR_ACK_EN.
`timescale 1ns/1ps
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 4,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [7:0] CMD_WR      = DEF_CMD_WR,
  parameter logic [7:0] CMD_RD      = DEF_CMD_RD,
  parameter logic [7:0] ACK_BYTE    = DEF_ACK_BYTE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [7:0]            WrData,
  input  logic [7:0]            RdData,
  input  logic                  RdData_Valid,
  output logic                  Cmd_Error
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8 || TIMEOUT_CYC < 2 || CMD_WR == CMD_RD ||
      ACK_BYTE == CMD_WR || ACK_BYTE == CMD_RD) begin : g_bad_cfg
    $error("uart_reg_bridge: inconsistent parameter set");
  end

`ifdef UART_REG_BRIDGE_WR_ACK_EN
  localparam logic [2:0] WR_DONE_STATE = ST_TX_SEND;
`else
  localparam logic [2:0] WR_DONE_STATE = ST_IDLE;
`endif

  logic [2:0] state;
  logic [2:0] next_state;
  logic       cmd_err_next;
  logic       byte_ok;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_expired;

  assign byte_ok = RX_D_VLD && !RX_ERR;
  assign tmr_en  = is_timed(state);
  assign tmr_clr = (next_state != state);

  uart_bridge_tmr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk     (CLK),
    .rst     (RST),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Next-state and error decision; a byte arriving in the expiry cycle beats the timeout.
  always_comb begin
    next_state   = state;
    cmd_err_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (byte_ok && RX_P_DATA == CMD_WR) begin
          next_state = ST_WR_ADDR;
        end else if (byte_ok && RX_P_DATA == CMD_RD) begin
          next_state = ST_RD_ADDR;
        end else begin
          cmd_err_next = RX_D_VLD;
        end
      end
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR: begin
        if (RX_D_VLD && RX_ERR) begin
          next_state   = ST_IDLE;
          cmd_err_next = 1'b1;
        end else if (RX_D_VLD) begin
          if (state == ST_WR_ADDR) begin
            next_state = ST_WR_DATA;
          end else if (state == ST_RD_ADDR) begin
            next_state = ST_RD_WAIT;
          end else begin
            next_state = WR_DONE_STATE;
          end
        end else if (tmr_expired) begin
          next_state   = ST_IDLE;
          cmd_err_next = 1'b1;
        end else begin
          next_state = state;
        end
      end
      ST_RD_WAIT: begin
        cmd_err_next = RX_D_VLD;
        if (RdData_Valid) begin
          next_state = ST_TX_SEND;
        end else if (tmr_expired) begin
          next_state   = ST_IDLE;
          cmd_err_next = 1'b1;
        end else begin
          next_state = state;
        end
      end
      ST_TX_SEND: begin
        cmd_err_next = RX_D_VLD;
        next_state   = TX_BUSY ? ST_TX_SEND : ST_TX_WAIT_HI;
      end
      ST_TX_WAIT_HI: begin
        cmd_err_next = RX_D_VLD;
        next_state   = TX_BUSY ? ST_TX_WAIT_LO : ST_TX_WAIT_HI;
      end
      ST_TX_WAIT_LO: begin
        cmd_err_next = RX_D_VLD;
        next_state   = TX_BUSY ? ST_TX_WAIT_LO : ST_IDLE;
      end
      default: begin
        next_state   = ST_IDLE;
        cmd_err_next = 1'b0;
      end
    endcase
  end

  // State, strobes and datapath registers; Address/WrData/TX_P_DATA only change on a load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      Cmd_Error <= 1'b0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= 8'h00;
      TX_P_DATA <= 8'h00;
    end else begin
      state     <= next_state;
      Cmd_Error <= cmd_err_next;
      WrEn      <= byte_ok && (state == ST_WR_DATA);
      RdEn      <= byte_ok && (state == ST_RD_ADDR);
      if (byte_ok && (state == ST_WR_ADDR || state == ST_RD_ADDR)) begin
        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
      end
      if (byte_ok && state == ST_WR_DATA) begin
        WrData <= RX_P_DATA;
      end
      if (state == ST_RD_WAIT && RdData_Valid) begin
        TX_P_DATA <= RdData;
      end
`ifdef UART_REG_BRIDGE_WR_ACK_EN
      else if (byte_ok && state == ST_WR_DATA) begin
        TX_P_DATA <= ACK_BYTE;
      end
`endif
    end
  end

  // Strobe combines with TX_BUSY so the byte goes out in the first idle transmitter cycle.
  assign TX_D_VLD = (state == ST_TX_SEND) && !TX_BUSY;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomised self-checking bench for uart_reg_bridge with a transaction-level expectation model.
`timescale 1ns/1ps
module tb_uart_reg_bridge;

  localparam int         AW  = 4;
  localparam int         TO  = 1024;
  localparam logic [7:0] CWR = 8'hAA;
  localparam logic [7:0] CRD = 8'hBB;
  localparam logic [7:0] ACK = 8'h5A;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    RX_P_DATA = 8'h00;
  logic          RX_D_VLD = 1'b0;
  logic          RX_ERR = 1'b0;
  logic [7:0]    TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_BUSY;
  logic          WrEn;
  logic          RdEn;
  logic [AW-1:0] Address;
  logic [7:0]    WrData;
  logic [7:0]    RdData = 8'h00;
  logic          RdData_Valid = 1'b0;
  logic          Cmd_Error;

  logic busy_force = 1'b0;
  logic busy_tx    = 1'b0;
  assign TX_BUSY = busy_force | busy_tx;

  uart_reg_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYC(TO), .CMD_WR(CWR), .CMD_RD(CRD), .ACK_BYTE(ACK)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .Cmd_Error(Cmd_Error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_tx_cyc = -1;
  int rd_lat = 2;
  int busy_len = 3;

  logic [7:0]  rf      [16];
  logic [7:0]  ref_mem [16];
  logic [11:0] wr_obs[$];
  logic [11:0] exp_wr[$];
  logic [7:0]  tx_obs[$];
  logic [7:0]  exp_tx[$];
  int err_obs = 0, exp_err = 0, rd_obs = 0, exp_rd = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Observation of every DUT strobe; the register file updates from WrEn.
  initial forever begin
    @(negedge CLK);
    if (WrEn) begin
      wr_obs.push_back({Address, WrData});
      rf[Address] = WrData;
    end
    if (RdEn) rd_obs++;
    if (TX_D_VLD) begin
      tx_obs.push_back(TX_P_DATA);
      last_tx_cyc = cyc;
    end
    if (Cmd_Error) err_obs++;
  end

  // Register-file read responder: data valid rd_lat cycles after the RdEn cycle.
  initial begin
    logic [AW-1:0] ra;
    int lat;
    forever begin
      @(negedge CLK);
      if (RdEn) begin
        ra  = Address;
        lat = rd_lat;
        repeat (lat) @(posedge CLK);
        #1;
        RdData       = rf[ra];
        RdData_Valid = 1'b1;
        @(posedge CLK);
        #1;
        RdData_Valid = 1'b0;
      end
    end
  end

  // Transmitter model: busy rises the cycle after a strobe and lasts busy_len cycles.
  initial forever begin
    @(negedge CLK);
    if (TX_D_VLD) begin
      @(posedge CLK);
      #1 busy_tx = 1'b1;
      repeat (busy_len) @(posedge CLK);
      #1 busy_tx = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(posedge CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    RX_ERR    = e;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
    RX_ERR    = 1'b0;
  endtask

  task automatic wait_tx(input int n0, input string tag);
    int g = 0;
    while (tx_obs.size() <= n0 && g < 3000) begin
      @(posedge CLK);
      g++;
    end
    check_eq({tag, " reply seen"}, 32'(tx_obs.size() > n0), 32'd1);
  endtask

  task automatic settle_and_compare(input string tag);
    idle(14);
    check_eq({tag, " wr count"}, wr_obs.size(), exp_wr.size());
    for (int i = 0; i < wr_obs.size() && i < exp_wr.size(); i++)
      check_eq({tag, " wr addr/data"}, wr_obs[i], exp_wr[i]);
    check_eq({tag, " tx count"}, tx_obs.size(), exp_tx.size());
    for (int i = 0; i < tx_obs.size() && i < exp_tx.size(); i++)
      check_eq({tag, " tx byte"}, tx_obs[i], exp_tx[i]);
    check_eq({tag, " rd count"}, rd_obs, exp_rd);
    check_eq({tag, " cmd_error"}, err_obs, exp_err);
    wr_obs.delete(); exp_wr.delete(); tx_obs.delete(); exp_tx.delete();
    err_obs = 0; exp_err = 0; rd_obs = 0; exp_rd = 0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
`ifdef UART_REG_BRIDGE_WR_ACK_EN
    int n0 = tx_obs.size();
`endif
    send_byte(CWR, 1'b0); idle(gap);
    send_byte(a, 1'b0);   idle(gap);
    send_byte(d, 1'b0);
    exp_wr.push_back({a[AW-1:0], d});
    ref_mem[a[AW-1:0]] = d;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
    exp_tx.push_back(ACK);
    wait_tx(n0, "wr ack");
`endif
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    int n0 = tx_obs.size();
    send_byte(CRD, 1'b0); idle(gap);
    send_byte(a, 1'b0);
    exp_rd++;
    exp_tx.push_back(ref_mem[a[AW-1:0]]);
    wait_tx(n0, "rd");
  endtask

  task automatic random_frame(input int idx);
    int         kind = $urandom_range(0, 5);
    int         gap  = $urandom_range(0, 4);
    int         k;
    int         n0;
    logic [7:0] a = 8'($urandom);
    logic [7:0] d = 8'($urandom);
    logic [7:0] op;
    logic [7:0] fb [3];
    rd_lat   = $urandom_range(1, 6);
    busy_len = $urandom_range(1, 8);
    case (kind)
      0: do_write(a, d, gap);
      1: do_read(a, gap);
      2: begin
        op = 8'($urandom);
        while (op == CWR || op == CRD) op = 8'($urandom);
        send_byte(op, 1'($urandom_range(0, 1)));
        exp_err++;
      end
      3: begin
        fb = '{CWR, a, d};
        k  = $urandom_range(0, 2);
        for (int j = 0; j <= k; j++) begin
          send_byte(fb[j], 1'(j == k));
          idle(gap);
        end
        exp_err++;
      end
      4: begin
        fb = '{CRD, a, d};
        k  = $urandom_range(0, 1);
        for (int j = 0; j <= k; j++) begin
          send_byte(fb[j], 1'(j == k));
          idle(gap);
        end
        exp_err++;
      end
      default: begin
        rd_lat = 8;
        n0 = tx_obs.size();
        send_byte(CRD, 1'b0);
        send_byte(a, 1'b0);
        idle(1);
        send_byte(8'($urandom), 1'($urandom_range(0, 1)));
        exp_rd++;
        exp_err++;
        exp_tx.push_back(ref_mem[a[AW-1:0]]);
        wait_tx(n0, "rd discard");
      end
    endcase
    settle_and_compare($sformatf("rnd%0d", idx));
  endtask

  initial begin
    int n0;
    int rel_cyc;
    for (int i = 0; i < 16; i++) begin
      rf[i]      = 8'($urandom);
      ref_mem[i] = rf[i];
    end

    idle(3);
    #1;
    check_eq("reset outputs", {WrEn, RdEn, TX_D_VLD, Cmd_Error, Address, WrData, TX_P_DATA}, 32'd0);
    RST = 1'b0;
    idle(2);

    do_write(8'h03, 8'hC5, 0);
    settle_and_compare("wr basic");

    rf[7] = 8'h3C; ref_mem[7] = 8'h3C;
    rd_lat = 2;
    do_read(8'h07, 0);
    settle_and_compare("rd basic");

    busy_force = 1'b1;
    n0 = tx_obs.size();
    send_byte(CRD, 1'b0);
    send_byte(8'h0A, 1'b0);
    exp_rd++;
    exp_tx.push_back(ref_mem[10]);
    idle(44);
    check_eq("holdoff quiet", tx_obs.size(), n0);
    @(posedge CLK);
    #1;
    busy_force = 1'b0;
    rel_cyc = cyc;
    wait_tx(n0, "holdoff");
    check_eq("holdoff strobe cycle", last_tx_cyc, rel_cyc);
    settle_and_compare("holdoff");

    send_byte(8'h12, 1'b0);
    send_byte(CWR, 1'b0);
    send_byte(8'h05, 1'b1);
    exp_err = 2;
    settle_and_compare("rx errors");

    send_byte(CWR, 1'b0);
    send_byte(8'h01, 1'b0);
    idle(TO + 2);
    exp_err = 1;
    settle_and_compare("wr timeout");
    do_write(8'h02, 8'hFF, 1);
    settle_and_compare("after timeout");

    send_byte(CWR, 1'b0);
    send_byte(8'h09, 1'b0);
    idle(TO - 2);
    send_byte(8'h66, 1'b0);
    exp_wr.push_back({4'h9, 8'h66});
    ref_mem[9] = 8'h66;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
    exp_tx.push_back(ACK);
`endif
    settle_and_compare("byte at expiry");

    rd_lat = TO + 5;
    send_byte(CRD, 1'b0);
    send_byte(8'h04, 1'b0);
    exp_rd = 1;
    exp_err = 1;
    idle(TO + 20);
    settle_and_compare("late rddata");

    send_byte(CWR, 1'b0);
    send_byte(8'h04, 1'b0);
    @(posedge CLK);
    #1 RST = 1'b1;
    idle(2);
    #1;
    check_eq("mid-frame reset outputs", {WrEn, RdEn, TX_D_VLD, Cmd_Error, Address, WrData, TX_P_DATA}, 32'd0);
    RST = 1'b0;
    settle_and_compare("mid-frame reset");
    do_write(8'h06, 8'h77, 0);
    settle_and_compare("after reset");

    for (int f = 0; f < 40; f++) random_frame(f);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
